window_gen_3x3: RTL and testbench
=================================

Name: window_gen_3x3

Overview:
- Streaming 3x3 neighbourhood generator for the RGB444 image pipeline.
- Accepts one 12-bit pixel per cycle in raster order.
- Emits, per pixel, the packed 108-bit window that the convolution effect blocks (sobel, blur, etc.) consume on their color_data input.
- Sits between the frame source (camera/ROM reader) and the effect blocks. Handles line buffering, border zeroing and end-of-frame flush.

Parameters:
- IMG_WIDTH, 160, pixels per line (≥3).
- IMG_HEIGHT, 120, lines per frame (≥2).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- pix_in  in  12  input pixel {R[11:8],G[7:4],B[3:0]}
- pix_valid  in  1  pix_in valid this cycle
- frame_start  in  1  marks pix_in as pixel (0,0); only meaningful with pix_valid
- in_ready  out  1  block accepts pix_in this cycle (accept = pix_valid & in_ready)
- window_out  out  108  packed window (layout below)
- window_valid  out  1  window_out valid, one-cycle pulse per window
- out_x  out  clog2(IMG_WIDTH)  centre column of window_out
- out_y  out  clog2(IMG_HEIGHT)  centre row of window_out
- out_eof  out  1  high with window_valid on the last window of the frame

Behaviour:
- Clock clk; reset asynchronous, active-high.
- Reset values: window_out=0, window_valid=0, out_x=0, out_y=0, out_eof=0, in_ready=1, state=IDLE, all counters 0. Buffered pixels are discarded on reset.
- window_out layout, 12 bits each, MSB first:
  - [107:96] centre
  - [95:84] left
  - [83:72] right
  - [71:60] up
  - [59:48] down
  - [47:36] upleft
  - [35:24] upright
  - [23:12] downleft
  - [11:0] downright
- Input index k counts accepted pixels in the frame (0..W*H-1). The window for centre index n = k-(W+1) is formed when input k is accepted. It is registered and presented on the next cycle with window_valid=1. Latency: W+2 cycles from centre pixel accept to its window at full rate.
- Border rule: neighbours outside the frame are forced to 12'h000.
  - cx=0: left, upleft, downleft = 0.
  - cx=W-1: right, upright, downright = 0.
  - cy=0: up, upleft, upright = 0.
  - cy=H-1: down, downleft, downright = 0.
  - There is no wrap-around between lines.
- FSM:
  - IDLE: in_ready=1. Pixels without frame_start are dropped. Accept with frame_start → pixel stored as k=0, go FILL.
  - FILL: in_ready=1, no windows. After input k=W accepted → RUN.
  - RUN: in_ready=1. Each accept produces one window (n=k-W-1). Accept of k=W*H-1 → FLUSH.
  - FLUSH: in_ready=0. pix_valid and frame_start are ignored. For exactly W+1 consecutive cycles, internal zero pseudo-pixels advance the pipeline, each producing one window. The window for n=W*H-1 has out_eof=1. Then → IDLE.
- Stalls: pix_valid low in FILL/RUN freezes the pipeline. No window is emitted and window_valid=0 that cycle.
- frame_start accepted in FILL or RUN: current frame aborted without eof or flush. Pending windows are discarded. The new pixel becomes k=0 and the state goes to FILL.
- Exactly W*H windows per completed frame, in raster order of centre. out_x/out_y match the centre.
- Storage implementation (shift register of 2W+3 or two line RAMs plus taps) is free. Only port-level timing is specified.

Test Plan (IMG_WIDTH=4, IMG_HEIGHT=3; pixel at index i = 12'(i+1)):
- Reset → window_out=0, window_valid=0, in_ready=1, out_eof=0.
- Stream 12 pixels back-to-back, frame_start on first. No window_valid for the first 5 accepts. Cycle after 6th accept → window_out={001,000,002,000,005,000,000,000,006}, out_x=0, out_y=0.
- Same stream → window for centre (1,1) appears the cycle after pixel 00B is accepted: {006,005,007,002,00A,001,003,009,00B}.
- After 12th accept → in_ready=0 for 5 cycles, 5 windows emitted. Last window = centre (3,2) {00C,00B,000,008,000,007,000,000,000} with out_eof=1. Then in_ready=1 and state IDLE. Total windows = 12.
- Drop pix_valid for 3 cycles mid-RUN → no window_valid during the gap. The window sequence resumes unchanged, with no duplicates or skips.
- Pixels sent in IDLE without frame_start are ignored, with no windows. Then frame_start asserted mid-frame (after 8 accepts) → restart: the next window is centre (0,0) of the new frame after 6 more accepts, with no out_eof from the aborted frame.

Source files
------------

// File: rtl/window_gen_3x3_if.sv
// window_gen_3x3_if: pixel-in / window-out bundle for the 3x3 window generator
interface window_gen_3x3_if #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120
);
    logic [11:0]                   pix_in;
    logic                          pix_valid;
    logic                          frame_start;
    logic                          in_ready;
    logic [107:0]                  window_out;
    logic                          window_valid;
    logic [$clog2(IMG_WIDTH)-1:0]  out_x;
    logic [$clog2(IMG_HEIGHT)-1:0] out_y;
    logic                          out_eof;

    modport master (
        output pix_in, pix_valid, frame_start,
        input  in_ready, window_out, window_valid, out_x, out_y, out_eof
    );

    modport slave (
        input  pix_in, pix_valid, frame_start,
        output in_ready, window_out, window_valid, out_x, out_y, out_eof
    );
endinterface

// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 neighbourhood generator with border zeroing and end-of-frame flush
module window_gen_3x3 #(
    parameter int IMG_WIDTH  = 160,
    parameter int IMG_HEIGHT = 120
) (
    input logic             clk,
    input logic             reset,
    window_gen_3x3_if.slave io
);
    localparam int W  = IMG_WIDTH;
    localparam int H  = IMG_HEIGHT;
    localparam int SW = 12 * (2 * W + 2);
    localparam int XW = $clog2(W);
    localparam int YW = $clog2(H);
    localparam int KW = $clog2(W * H + W + 1);
    localparam logic [1:0] IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, FLUSH = 2'd3;

    logic [1:0]   state_q, state_d;
    logic [KW-1:0] k_q, k_d;
    logic [XW-1:0] cx_q, cx_d, ox_q, ox_d;
    logic [YW-1:0] cy_q, cy_d, oy_q, oy_d;
    logic [SW-1:0] sr_q, sr_d;
    logic [107:0] win_q, win_d;
    logic         valid_q, valid_d, eof_q, eof_d;
    logic         acc, start, shift, emit, bl, br, bu, bd;
    logic [11:0]  px;
    // tap j holds the pixel accepted j inputs before the one entering now
    logic [SW+11:0] taps;

    always_comb begin
        acc     = io.pix_valid && state_q != FLUSH;
        start   = acc && io.frame_start;
        shift   = state_q == FLUSH || (acc && (state_q != IDLE || io.frame_start));
        emit    = state_q == FLUSH || (acc && !io.frame_start && state_q == RUN);
        px      = state_q == FLUSH ? 12'h000 : io.pix_in;
        taps    = {sr_q, px};
        bl      = cx_q == '0;
        br      = cx_q == XW'(W - 1);
        bu      = cy_q == '0;
        bd      = cy_q == YW'(H - 1);
        sr_d    = shift ? taps[SW-1:0] : sr_q;
        state_d = state_q;
        k_d     = k_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        win_d   = win_q;
        ox_d    = ox_q;
        oy_d    = oy_q;
        valid_d = 1'b0;
        eof_d   = 1'b0;
        if (start) begin
            state_d = FILL;
            k_d     = KW'(1);
            cx_d    = '0;
            cy_d    = '0;
        end else if (shift) begin
            k_d     = k_q + 1'b1;
            state_d = (state_q == FILL  && k_q == KW'(W))         ? RUN   :
                      (state_q == RUN   && k_q == KW'(W * H - 1)) ? FLUSH :
                      (state_q == FLUSH && k_q == KW'(W * H + W)) ? IDLE  : state_q;
        end
        if (emit) begin
            win_d   = {taps[12*(W+1) +: 12],
                       bl        ? 12'h000 : taps[12*(W+2) +: 12],
                       br        ? 12'h000 : taps[12*W +: 12],
                       bu        ? 12'h000 : taps[12*(2*W+1) +: 12],
                       bd        ? 12'h000 : taps[12 +: 12],
                       (bu || bl) ? 12'h000 : taps[12*(2*W+2) +: 12],
                       (bu || br) ? 12'h000 : taps[12*(2*W) +: 12],
                       (bd || bl) ? 12'h000 : taps[24 +: 12],
                       (bd || br) ? 12'h000 : taps[0 +: 12]};
            valid_d = 1'b1;
            ox_d    = cx_q;
            oy_d    = cy_q;
            eof_d   = br && bd;
            cx_d    = br ? '0 : cx_q + 1'b1;
            cy_d    = br ? cy_q + 1'b1 : cy_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            k_q     <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            sr_q    <= '0;
            win_q   <= '0;
            ox_q    <= '0;
            oy_q    <= '0;
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            sr_q    <= sr_d;
            win_q   <= win_d;
            ox_q    <= ox_d;
            oy_q    <= oy_d;
            valid_q <= valid_d;
            eof_q   <= eof_d;
        end
    end

    assign io.in_ready     = state_q != FLUSH;
    assign io.window_out   = win_q;
    assign io.window_valid = valid_q;
    assign io.out_x        = ox_q;
    assign io.out_y        = oy_q;
    assign io.out_eof      = eof_q;
endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: randomized and directed checks of window_gen_3x3 against an image-array reference model
module tb_window_gen_3x3;
    localparam int W = 4;
    localparam int H = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    window_gen_3x3_if #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) bus ();
    window_gen_3x3 #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (.clk(clk), .reset(reset), .io(bus));

    int n_chk = 0;
    int n_pass = 0;
    logic [11:0]  img [W*H];
    logic [107:0] rec [W*H];
    int k = 0;
    int fl_left = 0;
    int fl_n = 0;
    int nwin = 0;
    int neof = 0;
    bit in_frame = 1'b0;

    task automatic chk(input string tag, input logic [107:0] got, input logic [107:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [11:0] pix_at(input int x, input int y);
        if (x < 0 || x >= W || y < 0 || y >= H) return 12'h000;
        return img[y*W+x];
    endfunction

    function automatic logic [107:0] ref_win(input int n);
        int x, y;
        x = n % W;
        y = n / W;
        return {pix_at(x, y), pix_at(x-1, y), pix_at(x+1, y), pix_at(x, y-1), pix_at(x, y+1),
                pix_at(x-1, y-1), pix_at(x+1, y-1), pix_at(x-1, y+1), pix_at(x+1, y+1)};
    endfunction

    // one clock: drive inputs, predict, then check outputs just after the edge
    task automatic step(input logic v, input logic fs, input logic [11:0] p);
        bit ev;
        int en;
        bus.pix_valid   = v;
        bus.frame_start = fs;
        bus.pix_in      = p;
        #1;
        chk("in_ready", 108'(bus.in_ready), 108'(fl_left == 0));
        ev = 1'b0;
        en = 0;
        if (fl_left > 0) begin
            ev = 1'b1;
            en = fl_n;
            fl_n++;
            fl_left--;
        end else if (v) begin
            if (fs) begin
                in_frame = 1'b1;
                k = 0;
            end
            if (in_frame) begin
                img[k] = p;
                if (k >= W + 1) begin
                    ev = 1'b1;
                    en = k - W - 1;
                end
                if (k == W*H - 1) begin
                    fl_left = W + 1;
                    fl_n = k - W;
                    in_frame = 1'b0;
                end
                k++;
            end
        end
        @(posedge clk);
        #1;
        chk("window_valid", 108'(bus.window_valid), 108'(ev));
        if (bus.window_valid) nwin++;
        if (bus.window_valid && bus.out_eof) neof++;
        if (ev) begin
            chk("window_out", bus.window_out, ref_win(en));
            chk("out_x", 108'(bus.out_x), 108'(en % W));
            chk("out_y", 108'(bus.out_y), 108'(en / W));
            chk("out_eof", 108'(bus.out_eof), 108'(en == W*H - 1));
            rec[en] = bus.window_out;
        end
        @(negedge clk);
    endtask

    initial begin
        bit idle;
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.pix_in      = 12'h000;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_window_out", bus.window_out, 108'd0);
        chk("rst_window_valid", 108'(bus.window_valid), 108'd0);
        chk("rst_in_ready", 108'(bus.in_ready), 108'd1);
        chk("rst_out_eof", 108'(bus.out_eof), 108'd0);
        chk("rst_out_x", 108'(bus.out_x), 108'd0);
        chk("rst_out_y", 108'(bus.out_y), 108'd0);
        @(negedge clk);
        reset = 1'b0;

        // directed frame with pixel i = i+1
        for (int i = 0; i < W*H; i++) step(1'b1, i == 0, 12'(i + 1));
        repeat (7) step(1'b0, 1'b0, 12'h000);
        chk("dir_win00", rec[0], {12'h001, 12'h000, 12'h002, 12'h000, 12'h005, 12'h000, 12'h000, 12'h000, 12'h006});
        chk("dir_win11", rec[5], {12'h006, 12'h005, 12'h007, 12'h002, 12'h00A, 12'h001, 12'h003, 12'h009, 12'h00B});
        chk("dir_win32", rec[11], {12'h00C, 12'h00B, 12'h000, 12'h008, 12'h000, 12'h007, 12'h000, 12'h000, 12'h000});
        chk("dir_count", 108'(nwin), 108'(W*H));
        chk("dir_eof_count", 108'(neof), 108'd1);

        // stall of three cycles mid-frame
        nwin = 0;
        neof = 0;
        for (int i = 0; i < W*H; i++) begin
            if (i == 7) repeat (3) step(1'b0, 1'b0, 12'h000);
            step(1'b1, i == 0, 12'($urandom));
        end
        repeat (7) step(1'b0, 1'b0, 12'h000);
        chk("stall_count", 108'(nwin), 108'(W*H));
        chk("stall_eof_count", 108'(neof), 108'd1);

        // idle drops, then an aborted frame followed by a full one
        nwin = 0;
        neof = 0;
        repeat (3) step(1'b1, 1'b0, 12'($urandom));
        chk("idle_drop_count", 108'(nwin), 108'd0);
        for (int i = 0; i < 8; i++) step(1'b1, i == 0, 12'($urandom));
        for (int i = 0; i < W*H; i++) step(1'b1, i == 0, 12'($urandom));
        repeat (7) step(1'b0, 1'b0, 12'h000);
        chk("abort_count", 108'(nwin), 108'(3 + W*H));
        chk("abort_eof_count", 108'(neof), 108'd1);

        // random traffic, including inputs wiggling during flush
        for (int i = 0; i < 1500; i++) begin
            idle = !in_frame && fl_left == 0;
            step($urandom_range(0, 3) != 0,
                 idle ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 199) == 0),
                 12'($urandom));
        end
        repeat (8) step(1'b0, 1'b0, 12'h000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
